// File: rtl/counter_seg_display.sv
// rtl/counter_seg_display.sv - 4-digit multiplexed 7-segment driver for a slow-domain 4-bit count
// Shows the count as decimal on digits 1:0 and as one hex digit on digit 3; digit 2 stays blank.

module counter_seg_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 1000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count_in,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned    CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GUARD   = CW'(GUARD_CYC);
  localparam logic [6:0]     SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [3:0]    committed_q, committed_d;
  logic [3:0]    frame_q, frame_d;
  logic          first_q, first_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          wrap;
  logic          in_guard;
  logic [3:0]    units;
  logic          tens;
  logic [3:0]    digit_val;
  logic          digit_blank;
  logic [3:0]    an_sel;
  logic [6:0]    seg_code;

  function automatic logic [6:0] seg_rom(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Two-flop filter: a value only commits once both stages agree, so one-cycle glitches are dropped.
  always_comb begin
    s1_d        = count_in;
    s2_d        = s1_q;
    committed_d = committed_q;
    if (s1_q == s2_q) begin
      committed_d = s2_q;
    end
  end

  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    first_d = 1'b0;
    frame_d = frame_q;
    // The frame is only refreshed at a frame boundary so one scan never mixes two values.
    if (first_q || (wrap && (state_q == DIG3))) begin
      frame_d = committed_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wrap) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  always_comb begin
    tens        = (frame_q >= 4'd10);
    units       = tens ? (frame_q - 4'd10) : frame_q;
    in_guard    = (cnt_q < GUARD);
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    an_sel      = 4'b1111;
    case (state_q)
      DIG0: begin
        digit_val = units;
        an_sel    = 4'b1110;
      end
      DIG1: begin
        digit_val   = {3'b000, tens};
        digit_blank = LZ_BLANK && !tens;
        an_sel      = 4'b1101;
      end
      DIG2: begin
        digit_blank = 1'b1;
        an_sel      = 4'b1011;
      end
      default: begin
        digit_val = frame_q;
        an_sel    = 4'b0111;
      end
    endcase
    seg_code = digit_blank ? SEG_OFF : seg_rom(digit_val);
  end

  // Outputs are registered so nothing on the pins can glitch within a slot.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    if (!blank && !in_guard) begin
      an_d  = an_sel;
      seg_d = seg_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIG0;
      cnt_q       <= '0;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      committed_q <= 4'd0;
      frame_q     <= 4'd0;
      first_q     <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      committed_q <= committed_d;
      frame_q     <= frame_d;
      first_q     <= first_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_counter_seg_display.sv
// tb/tb_counter_seg_display.sv - directed bench for counter_seg_display (REFRESH_DIV=8, GUARD_CYC=2)

module tb_counter_seg_display;

  logic       clk;
  bit         clk_run;
  logic       rst_n;
  logic [3:0] count_in;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;

  int checks;
  int errors;
  int cyc;

  localparam logic [10:0] OFF = {4'b1111, 7'b1111111};

  counter_seg_display #(
    .REFRESH_DIV(8),
    .GUARD_CYC  (2),
    .LZ_BLANK   (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_in(count_in),
    .blank   (blank),
    .an      (an),
    .seg     (seg)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
               tag, got[10:7], got[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Advance until the output reflects slot position digit*8+off of the 32-cycle frame.
  task automatic wait_phase(input int d, input int off);
    int n;
    n = 0;
    tick();
    while ((((cyc - 1) % 32) != (d * 8 + off)) && (n < 64)) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: timed out waiting for digit %0d offset %0d", d, off);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b1;
    count_in = 4'd0;
    blank    = 1'b0;

    // 1. async reset without clock, then release
    #2 rst_n = 1'b0;
    #2 check("reset_async", {an, seg}, OFF);
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    check("guard_cyc0", {an, seg}, OFF);
    tick();
    check("guard_cyc1", {an, seg}, OFF);
    tick();
    check("first_d0", {an, seg}, {4'b1110, 7'b1000000});

    // 2. value 12
    count_in = 4'd12;
    wait_phase(0, 2);
    check("v12_d0", {an, seg}, {4'b1110, 7'b0100100});
    wait_phase(1, 4);
    check("v12_d1", {an, seg}, {4'b1101, 7'b1111001});
    wait_phase(2, 7);
    check("v12_d2", {an, seg}, {4'b1011, 7'b1111111});
    wait_phase(3, 1);
    check("v12_guard", {an, seg}, OFF);
    wait_phase(3, 2);
    check("v12_d3", {an, seg}, {4'b0111, 7'b1000110});

    // 3. value 5, leading zero blanked
    count_in = 4'd5;
    wait_phase(0, 3);
    check("v5_d0", {an, seg}, {4'b1110, 7'b0010010});
    wait_phase(1, 3);
    check("v5_d1", {an, seg}, {4'b1101, 7'b1111111});
    wait_phase(3, 5);
    check("v5_d3", {an, seg}, {4'b0111, 7'b0010010});

    // 4. glitch rejection and frame anti-tearing
    count_in = 4'd3;
    wait_phase(0, 4);
    count_in = 4'd7;
    tick();
    count_in = 4'd3;
    wait_phase(0, 2);
    check("glitch_d0", {an, seg}, {4'b1110, 7'b0110000});
    wait_phase(1, 2);
    check("glitch_d1", {an, seg}, {4'b1101, 7'b1111111});
    wait_phase(2, 3);
    count_in = 4'd9;
    wait_phase(3, 4);
    check("midframe_d3", {an, seg}, {4'b0111, 7'b0110000});
    wait_phase(0, 2);
    check("newframe_d0", {an, seg}, {4'b1110, 7'b0010000});

    // 5. blank keeps the scan running
    wait_phase(1, 4);
    blank = 1'b1;
    tick();
    check("blank_on", {an, seg}, OFF);
    repeat (9) tick();
    check("blank_hold", {an, seg}, OFF);
    blank = 1'b0;
    tick();
    check("blank_release", {an, seg}, {4'b1011, 7'b1111111});
    wait_phase(3, 3);
    check("blank_phase", {an, seg}, {4'b0111, 7'b0010000});

    // 6. reset pulse during DIG3
    wait_phase(3, 4);
    #1 rst_n = 1'b0;
    #1 check("rst_midop", {an, seg}, OFF);
    #1 rst_n = 1'b1;
    cyc = 0;
    tick();
    check("rst_guard", {an, seg}, OFF);
    tick();
    tick();
    check("rst_d0", {an, seg}, {4'b1110, 7'b1000000});
    wait_phase(3, 2);
    check("rst_d3", {an, seg}, {4'b0111, 7'b1000000});
    wait_phase(0, 2);
    check("rst_recommit", {an, seg}, {4'b1110, 7'b0010000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
